corr_window_accumulator: RTL and testbench
==========================================

// Module: corr_window_accumulator
// PURPOSE
//  Consumer side of the correlation line datapath: takes one set of per-line sums per accepted beat
//  (sum I^2, sum I, sum T*I per template) and accumulates NUM_OF_LINES beats into window totals.
//  Sits directly after template_datapath; feeds the NCC score / match-decision stage over valid/ready.
// PARAMETERS
//  PIXEL_SIZE    8  pixel width in bits
//  LINE_SIZE     5  pixels per line; sets the line-sum width LSW = $clog2(LINE_SIZE)+2*PIXEL_SIZE (19)
//  NUM_OF_LINES  5  lines per window; window width WSW = LSW+$clog2(NUM_OF_LINES) (22)
//  NUM_TEMPLATES 2  templates correlated in parallel
// PORTS
//  CLK            in   1                  clock; all logic on the rising edge
//  RST_N          in   1                  synchronous reset, active-low
//  flush          in   1                  drop the partial window and return to ACCUM, line 0
//  in_valid       in   1                  line sums are valid this cycle
//  in_ready       out  1                  block accepts a line this cycle
//  in_sq_sum      in   LSW                sum of I^2 over the line
//  in_i_sum       in   LSW                sum of I over the line
//  in_txi_sum     in   LSW x NUM_TEMPLATES sum of T*I per template
//  out_valid      out  1                  window totals are valid
//  out_ready      in   1                  downstream accepts the totals
//  out_sq_sum     out  WSW                window sum of I^2
//  out_i_sum      out  WSW                window sum of I
//  out_txi_sum    out  WSW x NUM_TEMPLATES window sum of T*I per template
//  out_win_cnt    out  16                 index of the window on the outputs; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (RST_N=0 at an edge): state=ACCUM, line_cnt=0, accumulators=0, out_valid=0, all out_* sums=0,
//    out_win_cnt=0. A reset in the middle of a window discards that window; nothing is emitted.
//  - Line accept = in_valid & in_ready. Sums are zero-extended to WSW and added. WSW holds the maximum
//    window value, so no overflow or saturation logic is needed.
//  - FSM ACCUM: in_ready=1. An accept with line_cnt<NUM_OF_LINES-1 updates acc+=in and line_cnt++.
//    An accept with line_cnt==NUM_OF_LINES-1 loads out_*=acc+in, sets out_valid=1, clears acc and
//    line_cnt, and moves to HOLD. Latency from the last line accepted to out_valid is 1 cycle.
//  - FSM HOLD: out_* stay stable while out_valid=1 & out_ready=0. in_ready=out_ready, so a new line is
//    accepted only in the cycle the window is taken.
//    out_valid & out_ready: out_valid=0 next cycle (unless NUM_OF_LINES==1 and a line is accepted in
//    the same cycle, which reloads the outputs), out_win_cnt++, state returns to ACCUM. A line accepted
//    in that same cycle becomes line 0 of the next window (acc=in, line_cnt=1).
//  - flush has priority over everything except reset. It clears acc and line_cnt, sets state=ACCUM and
//    out_valid=0, and drops a line presented in the same cycle. out_win_cnt is unchanged.
//  - Between bursts in_valid may drop for any number of cycles; the accumulation is held.
// CONFIGURATION
//  - Macro CORR_BEST_MATCH_EN, when defined, adds two outputs:
//    - out_best_idx [$clog2(NUM_TEMPLATES)]: index of the largest out_txi_sum; a tie goes to the
//      lowest index.
//    - out_best_val [WSW]: that largest value.
//    Both are combinational from the registered out_txi_sum, so they are valid together with
//    out_valid with no added latency. Under reset both read 0.
//  - Without the macro these ports do not exist and no compare logic is built.
// STRUCTURE
//  - Package corr_pkg: PIXEL_SIZE, LINE_SIZE, NUM_OF_LINES and NUM_TEMPLATES as the shared defaults;
//    localparams LSW and WSW; typedef enum logic {ACCUM, HOLD} acc_state_t; typedef line_sum_t /
//    win_sum_t packed vectors.
//  - Sub-module corr_argmax: a combinational compare tree over NUM_TEMPLATES win_sum_t values,
//    instantiated only under CORR_BEST_MATCH_EN.
// TESTING
//  1. 5 back-to-back lines, each sq=100 i=10 txi={7,3}, out_ready=1 -> out_valid one cycle after the
//     5th accept; sums 500/50/{35,15}; out_win_cnt=0, then 1.
//  2. out_ready=0 for 4 cycles after a window -> out_* stable, in_ready=0, no line lost;
//     release with in_valid=1 -> that line becomes line 0 of window 2.
//  3. All inputs at maximum (sq=5*255^2=325125) for 5 lines -> out_sq_sum=1625625, with no wrap.
//  4. flush after line 3, same cycle as in_valid -> that line is dropped; the next 5 lines form a
//     window containing only those lines.
//  5. RST_N low after line 2 -> all outputs 0 next cycle; the window restarts at line_cnt=0.
//  6. (CORR_BEST_MATCH_EN) txi totals {40,40} -> best_idx=0; totals {10,90} -> best_idx=1,
//     best_val=90.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared configuration and types for the correlation window accumulator.
package corr_pkg;

  localparam int PIXEL_SIZE    = 8;
  localparam int LINE_SIZE     = 5;
  localparam int NUM_OF_LINES  = 5;
  localparam int NUM_TEMPLATES = 2;

  localparam int LSW = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
  localparam int WSW = LSW + $clog2(NUM_OF_LINES);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  typedef logic [LSW-1:0] line_sum_t;
  typedef logic [WSW-1:0] win_sum_t;

endpackage

// File: rtl/corr_argmax.sv
// Combinational best-match selector over the per-template window totals.
// A tie resolves to the lowest index because only a strictly larger value replaces the leader.
module corr_argmax #(
  parameter int N  = corr_pkg::NUM_TEMPLATES,
  parameter int W  = corr_pkg::WSW,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0][W-1:0] vals,
  output logic [IW-1:0]       best_idx,
  output logic [W-1:0]        best_val
);

  // Scan the totals, keeping the first maximum seen.
  always_comb begin
    best_idx = '0;
    best_val = vals[0];
    for (int k = 1; k < N; k++) begin
      if (vals[k] > best_val) begin
        best_val = vals[k];
        best_idx = IW'(k);
      end else begin
        best_val = best_val;
        best_idx = best_idx;
      end
    end
  end

endmodule

// File: rtl/corr_window_accumulator.sv
// Accumulates NUM_OF_LINES accepted line sums into registered window totals (valid/ready out).
// Optional macro CORR_BEST_MATCH_EN adds out_best_idx / out_best_val via corr_argmax.
module corr_window_accumulator #(
  parameter int PIXEL_SIZE    = corr_pkg::PIXEL_SIZE,
  parameter int LINE_SIZE     = corr_pkg::LINE_SIZE,
  parameter int NUM_OF_LINES  = corr_pkg::NUM_OF_LINES,
  parameter int NUM_TEMPLATES = corr_pkg::NUM_TEMPLATES,
  localparam int LSW = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
  localparam int WSW = LSW + $clog2(NUM_OF_LINES)
`ifdef CORR_BEST_MATCH_EN
  ,
  localparam int IW = (NUM_TEMPLATES > 1) ? $clog2(NUM_TEMPLATES) : 1
`endif
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LSW-1:0]                    in_sq_sum,
  input  logic [LSW-1:0]                    in_i_sum,
  input  logic [NUM_TEMPLATES-1:0][LSW-1:0] in_txi_sum,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WSW-1:0]                    out_sq_sum,
  output logic [WSW-1:0]                    out_i_sum,
  output logic [NUM_TEMPLATES-1:0][WSW-1:0] out_txi_sum,
  output logic [15:0]                       out_win_cnt
`ifdef CORR_BEST_MATCH_EN
  ,
  output logic [IW-1:0]                     out_best_idx,
  output logic [WSW-1:0]                    out_best_val
`endif
);

  import corr_pkg::*;

  localparam int CW = (NUM_OF_LINES > 1) ? $clog2(NUM_OF_LINES) : 1;
  localparam logic [CW-1:0] LAST_LINE = CW'(NUM_OF_LINES - 1);

  acc_state_t                        state_r;
  logic [CW-1:0]                     line_cnt_r;
  logic [WSW-1:0]                    acc_sq_r;
  logic [WSW-1:0]                    acc_i_r;
  logic [NUM_TEMPLATES-1:0][WSW-1:0] acc_txi_r;

  logic [WSW-1:0]                    sum_sq_s;
  logic [WSW-1:0]                    sum_i_s;
  logic [NUM_TEMPLATES-1:0][WSW-1:0] sum_txi_s;

  // Running total including the line on the inputs; WSW covers a full window so no wrap is possible.
  always_comb begin
    sum_sq_s = acc_sq_r + WSW'(in_sq_sum);
    sum_i_s  = acc_i_r + WSW'(in_i_sum);
    for (int k = 0; k < NUM_TEMPLATES; k++) begin
      sum_txi_s[k] = acc_txi_r[k] + WSW'(in_txi_sum[k]);
    end
  end

  // Ready is held off while a finished window waits, except in the cycle it is taken.
  always_comb begin
    in_ready = 1'b1;
    case (state_r)
      ACCUM:   in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b1;
    endcase
  end

  // Window FSM, accumulators and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= ACCUM;
      line_cnt_r  <= '0;
      acc_sq_r    <= '0;
      acc_i_r     <= '0;
      acc_txi_r   <= '0;
      out_valid   <= 1'b0;
      out_sq_sum  <= '0;
      out_i_sum   <= '0;
      out_txi_sum <= '0;
      out_win_cnt <= 16'd0;
    end else if (flush) begin
      state_r    <= ACCUM;
      line_cnt_r <= '0;
      acc_sq_r   <= '0;
      acc_i_r    <= '0;
      acc_txi_r  <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (in_valid) begin
            if (line_cnt_r == LAST_LINE) begin
              out_sq_sum  <= sum_sq_s;
              out_i_sum   <= sum_i_s;
              out_txi_sum <= sum_txi_s;
              out_valid   <= 1'b1;
              acc_sq_r    <= '0;
              acc_i_r     <= '0;
              acc_txi_r   <= '0;
              line_cnt_r  <= '0;
              state_r     <= HOLD;
            end else begin
              acc_sq_r   <= sum_sq_s;
              acc_i_r    <= sum_i_s;
              acc_txi_r  <= sum_txi_s;
              line_cnt_r <= line_cnt_r + CW'(1);
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_win_cnt <= out_win_cnt + 16'd1;
            if (in_valid && (NUM_OF_LINES == 1)) begin
              // Single-line windows complete immediately, so the outputs reload in place.
              out_sq_sum  <= WSW'(in_sq_sum);
              out_i_sum   <= WSW'(in_i_sum);
              for (int k = 0; k < NUM_TEMPLATES; k++) begin
                out_txi_sum[k] <= WSW'(in_txi_sum[k]);
              end
              out_valid <= 1'b1;
              state_r   <= HOLD;
            end else if (in_valid) begin
              acc_sq_r   <= WSW'(in_sq_sum);
              acc_i_r    <= WSW'(in_i_sum);
              for (int k = 0; k < NUM_TEMPLATES; k++) begin
                acc_txi_r[k] <= WSW'(in_txi_sum[k]);
              end
              line_cnt_r <= CW'(1);
              out_valid  <= 1'b0;
              state_r    <= ACCUM;
            end else begin
              out_valid <= 1'b0;
              state_r   <= ACCUM;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r    <= ACCUM;
          line_cnt_r <= '0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CORR_BEST_MATCH_EN
  corr_argmax #(
    .N (NUM_TEMPLATES),
    .W (WSW)
  ) u_argmax (
    .vals     (out_txi_sum),
    .best_idx (out_best_idx),
    .best_val (out_best_val)
  );
`endif

endmodule

// File: tb/tb_corr_window_accumulator.sv
// Self-checking bench: directed scenarios then random traffic against a queue-based window model.
module tb_corr_window_accumulator;

  import corr_pkg::*;

  localparam int NT = NUM_TEMPLATES;
  localparam int N  = NUM_OF_LINES;

  logic                   CLK;
  logic                   RST_N;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [LSW-1:0]         in_sq_sum;
  logic [LSW-1:0]         in_i_sum;
  logic [NT-1:0][LSW-1:0] in_txi_sum;
  logic                   out_valid;
  logic                   out_ready;
  logic [WSW-1:0]         out_sq_sum;
  logic [WSW-1:0]         out_i_sum;
  logic [NT-1:0][WSW-1:0] out_txi_sum;
  logic [15:0]            out_win_cnt;
`ifdef CORR_BEST_MATCH_EN
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;
  logic [IW-1:0]          out_best_idx;
  logic [WSW-1:0]         out_best_val;
`endif

  corr_window_accumulator dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sq_sum   (in_sq_sum),
    .in_i_sum    (in_i_sum),
    .in_txi_sum  (in_txi_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sq_sum  (out_sq_sum),
    .out_i_sum   (out_i_sum),
    .out_txi_sum (out_txi_sum),
    .out_win_cnt (out_win_cnt)
`ifdef CORR_BEST_MATCH_EN
    ,
    .out_best_idx (out_best_idx),
    .out_best_val (out_best_val)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: accepted lines are queued; a full queue becomes a window total.
  logic                   m_valid = 1'b0;
  logic [WSW-1:0]         m_sq    = '0;
  logic [WSW-1:0]         m_i     = '0;
  logic [NT-1:0][WSW-1:0] m_txi   = '0;
  logic [15:0]            m_cnt   = 16'd0;
  logic [LSW-1:0]         q_sq[$];
  logic [LSW-1:0]         q_i[$];
  logic [NT-1:0][LSW-1:0] q_txi[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [NT-1:0][LSW-1:0] mk_txi(input int a, input int b);
    logic [NT-1:0][LSW-1:0] t;
    for (int k = 0; k < NT; k++) t[k] = (k == 0) ? LSW'(a) : LSW'(b);
    return t;
  endfunction

  task automatic model_edge();
    logic rdy;
    if (!RST_N) begin
      q_sq.delete(); q_i.delete(); q_txi.delete();
      m_valid = 1'b0; m_sq = '0; m_i = '0; m_txi = '0; m_cnt = 16'd0;
    end else if (flush) begin
      q_sq.delete(); q_i.delete(); q_txi.delete();
      m_valid = 1'b0;
    end else begin
      rdy = !m_valid || out_ready;
      if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_cnt   = m_cnt + 16'd1;
      end
      if (in_valid && rdy) begin
        q_sq.push_back(in_sq_sum);
        q_i.push_back(in_i_sum);
        q_txi.push_back(in_txi_sum);
        if (q_sq.size() == N) begin
          m_sq = '0; m_i = '0; m_txi = '0;
          for (int j = 0; j < N; j++) begin
            m_sq = m_sq + WSW'(q_sq[j]);
            m_i  = m_i + WSW'(q_i[j]);
            for (int k = 0; k < NT; k++) m_txi[k] = m_txi[k] + WSW'(q_txi[j][k]);
          end
          m_valid = 1'b1;
          q_sq.delete(); q_i.delete(); q_txi.delete();
        end
      end
    end
  endtask

  task automatic check_outputs();
`ifdef CORR_BEST_MATCH_EN
    int             bi;
    logic [WSW-1:0] bv;
`endif
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_win_cnt", 64'(out_win_cnt), 64'(m_cnt));
    chk("out_sq_sum", 64'(out_sq_sum), 64'(m_sq));
    chk("out_i_sum", 64'(out_i_sum), 64'(m_i));
    chk("out_txi_sum", 64'(out_txi_sum), 64'(m_txi));
`ifdef CORR_BEST_MATCH_EN
    bi = 0;
    bv = m_txi[0];
    for (int k = 1; k < NT; k++) begin
      if (m_txi[k] > bv) begin
        bv = m_txi[k];
        bi = k;
      end
    end
    chk("out_best_idx", 64'(out_best_idx), 64'(bi));
    chk("out_best_val", 64'(out_best_val), 64'(bv));
`endif
  endtask

  task automatic step(input logic v, input int sq, input int isum, input logic [NT-1:0][LSW-1:0] txi,
                      input logic ordy, input logic fl, input logic rst);
    @(negedge CLK);
    RST_N      = !rst;
    flush      = fl;
    in_valid   = v;
    in_sq_sum  = LSW'(sq);
    in_i_sum   = LSW'(isum);
    in_txi_sum = txi;
    out_ready  = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    RST_N = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sq_sum = '0; in_i_sum = '0; in_txi_sum = '0;

    // Reset state
    step(1'b0, 0, 0, mk_txi(0, 0), 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, mk_txi(0, 0), 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(out_win_cnt), 64'd0);

    // 1: five back-to-back lines, taken immediately
    for (int j = 0; j < N; j++) step(1'b1, 100, 10, mk_txi(7, 3), 1'b1, 1'b0, 1'b0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_sq", 64'(out_sq_sum), 64'd500);
    chk("t1_i", 64'(out_i_sum), 64'd50);
    chk("t1_txi0", 64'(out_txi_sum[0]), 64'd35);
    chk("t1_txi1", 64'(out_txi_sum[1]), 64'd15);
    chk("t1_cnt0", 64'(out_win_cnt), 64'd0);
    step(1'b0, 0, 0, mk_txi(0, 0), 1'b1, 1'b0, 1'b0);
    chk("t1_cnt1", 64'(out_win_cnt), 64'd1);
    chk("t1_drop", 64'(out_valid), 64'd0);

    // 2: back-pressure for 4 cycles, then release with a line presented
    for (int j = 0; j < N; j++) step(1'b1, 100, 10, mk_txi(7, 3), 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 9, 1, mk_txi(2, 4), 1'b0, 1'b0, 1'b0);
      chk("t2_ready_low", 64'(in_ready), 64'd0);
      chk("t2_hold_sq", 64'(out_sq_sum), 64'd500);
    end
    step(1'b1, 9, 1, mk_txi(2, 4), 1'b1, 1'b0, 1'b0);
    for (int j = 1; j < N; j++) step(1'b1, 1, 1, mk_txi(1, 1), 1'b1, 1'b0, 1'b0);
    chk("t2_sq", 64'(out_sq_sum), 64'(9 + N - 1));
    step(1'b0, 0, 0, mk_txi(0, 0), 1'b1, 1'b0, 1'b0);

    // 3: maximum line values, no wrap
    for (int j = 0; j < N; j++) step(1'b1, 325125, 1275, mk_txi(325125, 325125), 1'b1, 1'b0, 1'b0);
    chk("t3_sq", 64'(out_sq_sum), 64'd1625625);
    chk("t3_txi1", 64'(out_txi_sum[1]), 64'd1625625);
    step(1'b0, 0, 0, mk_txi(0, 0), 1'b1, 1'b0, 1'b0);

    // 4: flush with a line presented after 3 lines
    for (int j = 0; j < 3; j++) step(1'b1, 1000, 100, mk_txi(50, 60), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1000, 100, mk_txi(50, 60), 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < N; j++) step(1'b1, 11 + j, 2, mk_txi(3, 4), 1'b1, 1'b0, 1'b0);
    chk("t4_sq", 64'(out_sq_sum), 64'(11 * N + (N * (N - 1)) / 2));
    step(1'b0, 0, 0, mk_txi(0, 0), 1'b1, 1'b0, 1'b0);

    // 5: reset mid-window
    for (int j = 0; j < 2; j++) step(1'b1, 77, 7, mk_txi(5, 5), 1'b1, 1'b0, 1'b0);
    step(1'b1, 77, 7, mk_txi(5, 5), 1'b1, 1'b0, 1'b1);
    chk("t5_sq0", 64'(out_sq_sum), 64'd0);
    chk("t5_cnt0", 64'(out_win_cnt), 64'd0);
    for (int j = 0; j < N; j++) step(1'b1, 20, 2, mk_txi(1, 2), 1'b1, 1'b0, 1'b0);
    chk("t5_sq", 64'(out_sq_sum), 64'(20 * N));

`ifdef CORR_BEST_MATCH_EN
    // 6: best-match tie and clear winner
    for (int j = 0; j < N; j++) step(1'b1, 1, 1, mk_txi(8, 8), 1'b1, 1'b0, 1'b0);
    chk("t6_tie_idx", 64'(out_best_idx), 64'd0);
    for (int j = 0; j < N; j++) step(1'b1, 1, 1, mk_txi(2, 18), 1'b1, 1'b0, 1'b0);
    chk("t6_idx", 64'(out_best_idx), 64'd1);
    chk("t6_val", 64'(out_best_val), 64'd90);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(1'b1 && ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 325125)), int'($urandom_range(0, 1275)),
           mk_txi(int'($urandom_range(0, 325125)), int'($urandom_range(0, 325125))),
           $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
